// File: rtl/mac_pkg.sv
// Shared widths for the MAC multiply-add datapath.
package mac_pkg;

    localparam int unsigned A_W     = 8;
    localparam int unsigned ACC_W   = 32;
    localparam int unsigned PROD_W  = 2 * A_W;
    localparam int unsigned GRP_W   = 4;
    localparam int unsigned N_GROUP = ACC_W / GRP_W;

endpackage

// File: rtl/cla_adder_32.sv
// 32-bit combinational adder: 4-bit carry-lookahead groups, group carry rippled between them.
module cla_adder_32
    import mac_pkg::*;
(
    input  logic [ACC_W-1:0] a_i,
    input  logic [ACC_W-1:0] b_i,
    input  logic             cin_i,
    output logic [ACC_W-1:0] s_o,
    output logic             cout_o
);

    logic [N_GROUP:0] grp_c;

    assign grp_c[0] = cin_i;

    for (genvar k = 0; k < N_GROUP; k++) begin : g_grp
        logic [GRP_W-1:0] g;
        logic [GRP_W-1:0] p;
        logic [GRP_W:0]   c;

        assign g = a_i[k*GRP_W +: GRP_W] & b_i[k*GRP_W +: GRP_W];
        assign p = a_i[k*GRP_W +: GRP_W] ^ b_i[k*GRP_W +: GRP_W];

        // Lookahead carries, each expanded directly from the group carry-in.
        assign c[0] = grp_c[k];
        assign c[1] = g[0] | (p[0] & c[0]);
        assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
        assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
                    | (p[2] & p[1] & p[0] & c[0]);
        assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
                    | (p[3] & p[2] & p[1] & g[0])
                    | (p[3] & p[2] & p[1] & p[0] & c[0]);

        assign s_o[k*GRP_W +: GRP_W] = p ^ c[GRP_W-1:0];
        assign grp_c[k+1]            = c[GRP_W];
    end

    assign cout_o = grp_c[N_GROUP];

endmodule

// File: rtl/multiplier_adder_32bit.sv
// Registered unsigned multiply-add: product = a*b, {carry_out, sum} = a*b + addend.
module multiplier_adder_32bit
    import mac_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [A_W-1:0]   a,
    input  logic [A_W-1:0]   b,
    input  logic [ACC_W-1:0] addend,
    output logic [ACC_W-1:0] product,
    output logic [ACC_W-1:0] sum,
    output logic             carry_out,
    output logic             valid
);

    logic [ACC_W-1:0] pp [A_W];
    logic [ACC_W-1:0] acc [A_W+1];
    logic [A_W-1:0]   unused_row_cout;

    logic [ACC_W-1:0] product_d, product_q;
    logic [ACC_W-1:0] sum_d, sum_q;
    logic             carry_d, carry_q;
    logic             valid_q;

    assign acc[0] = '0;

    // Shift-and-add array: row i adds a<<i when b[i] is set. Rows never exceed
    // PROD_W bits, so the upper adder inputs stay zero and row carries are always 0.
    for (genvar i = 0; i < A_W; i++) begin : g_row
        assign pp[i] = b[i] ? (ACC_W'(a) << i) : '0;

        cla_adder_32 u_row (
            .a_i   (acc[i]),
            .b_i   (pp[i]),
            .cin_i (1'b0),
            .s_o   (acc[i+1]),
            .cout_o(unused_row_cout[i])
        );
    end

    assign product_d = acc[A_W];

    cla_adder_32 u_sum (
        .a_i   (product_d),
        .b_i   (addend),
        .cin_i (1'b0),
        .s_o   (sum_d),
        .cout_o(carry_d)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            product_q <= '0;
            sum_q     <= '0;
            carry_q   <= 1'b0;
            valid_q   <= 1'b0;
        end else if (en) begin
            product_q <= product_d;
            sum_q     <= sum_d;
            carry_q   <= carry_d;
            valid_q   <= 1'b1;
        end else begin
            valid_q   <= 1'b0;
        end
    end

    assign product   = product_q;
    assign sum       = sum_q;
    assign carry_out = carry_q;
    assign valid     = valid_q;

endmodule

// File: tb/tb_multiplier_adder_32bit.sv
// Directed and random checks of the registered multiply-add against a behavioural model.
module tb_multiplier_adder_32bit;

    logic        clk = 1'b0;
    logic        reset;
    logic        en;
    logic [7:0]  a;
    logic [7:0]  b;
    logic [31:0] addend;
    logic [31:0] product;
    logic [31:0] sum;
    logic        carry_out;
    logic        valid;

    int total = 0;
    int bad   = 0;

    logic [31:0] exp_product;
    logic [31:0] exp_sum;
    logic        exp_carry;
    logic        exp_valid;
    logic [32:0] full;

    always #5 clk = ~clk;

    multiplier_adder_32bit dut (
        .clk      (clk),
        .reset    (reset),
        .en       (en),
        .a        (a),
        .b        (b),
        .addend   (addend),
        .product  (product),
        .sum      (sum),
        .carry_out(carry_out),
        .valid    (valid)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset  = 1'b1;
        en     = 1'b1;
        a      = 8'd3;
        b      = 8'd5;
        addend = 32'd0;
        tick();
        tick();
        check("rst_product", product, 32'd0);
        check("rst_sum", sum, 32'd0);
        check("rst_carry", 32'(carry_out), 32'd0);
        check("rst_valid", 32'(valid), 32'd0);

        reset = 1'b0;
        tick();
        check("basic_product", product, 32'd15);
        check("basic_sum", sum, 32'd15);
        check("basic_carry", 32'(carry_out), 32'd0);
        check("basic_valid", 32'(valid), 32'd1);

        a = 8'd255; b = 8'd255; addend = 32'hFFFF_FFFF;
        tick();
        check("wrap_product", product, 32'h0000_FE01);
        check("wrap_sum", sum, 32'h0000_FE00);
        check("wrap_carry", 32'(carry_out), 32'd1);
        check("wrap_valid", 32'(valid), 32'd1);

        a = 8'd10; b = 8'd20; addend = 32'd100;
        tick();
        check("hold_cap_product", product, 32'd200);
        check("hold_cap_sum", sum, 32'd300);
        en = 1'b0; a = 8'd1; b = 8'd1; addend = 32'd0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("hold_sum", sum, 32'd300);
            check("hold_product", product, 32'd200);
            check("hold_carry", 32'(carry_out), 32'd0);
            check("hold_valid", 32'(valid), 32'd0);
        end

        reset = 1'b1; en = 1'b1; a = 8'd7; b = 8'd9;
        tick();
        check("rprio_sum", sum, 32'd0);
        check("rprio_product", product, 32'd0);
        check("rprio_valid", 32'(valid), 32'd0);
        reset = 1'b0;
        tick();
        check("rprio_next_sum", sum, 32'd63);
        check("rprio_next_valid", 32'(valid), 32'd1);

        exp_product = 32'd63;
        exp_sum     = 32'd63;
        exp_carry   = 1'b0;
        for (int n = 0; n < 10000; n++) begin
            a      = 8'($urandom);
            b      = 8'($urandom);
            addend = (n % 16 == 0) ? 32'hFFFF_FFFF - 32'($urandom_range(0, 70000)) : $urandom;
            en     = 1'($urandom);
            if (en) begin
                full        = 33'(32'(a) * 32'(b)) + 33'(addend);
                exp_product = 32'(a) * 32'(b);
                exp_sum     = full[31:0];
                exp_carry   = full[32];
            end
            exp_valid = en;
            tick();
            check("rand_product", product, exp_product);
            check("rand_sum", sum, exp_sum);
            check("rand_carry", 32'(carry_out), 32'(exp_carry));
            check("rand_valid", 32'(valid), 32'(exp_valid));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
